// File: rtl/deser_param_pkg.sv
// Shared types, width helpers and parameter check for the deser_param slice.
// The optional partial-word flush is enabled by defining DESER_FLUSH_EN.
package deser_param_pkg;

    typedef enum logic [0:0] {StIdle, StFill} lane_state_e;

    function automatic int unsigned mod_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    // A single-beat word still needs one counter bit.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

`define DESER_PARAM_CHECK(DW, LW) \
    if (((DW) < (LW)) || (((DW) % (LW)) != 0)) begin : g_bad_width \
        $error("deser_param: DATA_W must be a multiple of LANE_W and >= LANE_W"); \
    end

// File: rtl/deser_param_if.sv
// Beat input and word output bundle of deser_param.
// master: beat producer / word consumer side; slave: the deserializer.
interface deser_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 1
);
    localparam int unsigned MOD_W = $clog2(DATA_W + 1);

    logic [LANE_W-1:0] data_i;
    logic              data_val_i;
    logic              flush_i;
    logic [DATA_W-1:0] deser_data_o;
    logic              deser_data_val_o;
    logic [MOD_W-1:0]  deser_data_mod_o;

    modport master (
        output data_i, data_val_i, flush_i,
        input  deser_data_o, deser_data_val_o, deser_data_mod_o
    );

    modport slave (
        input  data_i, data_val_i, flush_i,
        output deser_data_o, deser_data_val_o, deser_data_mod_o
    );
endinterface

// File: rtl/deser_param_lane_shift.sv
// Placement register and beat counter: drops each accepted beat into its final word slot.
// o_word already includes the beat accepted this cycle, so the top can register it directly.
module deser_param_lane_shift
    import deser_param_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LANE_W    = 1,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned BEATS    = DATA_W / LANE_W,
    localparam int unsigned CNT_W    = cnt_width(BEATS)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [LANE_W-1:0] i_beat,
    input  logic              i_val,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_last,
    output logic              o_held
);

    lane_state_e       r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DATA_W-1:0] r_word, w_word_next, w_word_merged;
    logic [31:0]       w_shift;
    logic              w_last;

    always_comb begin
        w_shift = (MSB_FIRST) ? (BEATS - 1 - 32'(r_cnt)) * LANE_W : 32'(r_cnt) * LANE_W;
        w_word_merged = r_word;
        if (i_val) begin
            w_word_merged = r_word | (DATA_W'(i_beat) << w_shift);
        end
        w_last = i_val && (r_cnt == CNT_W'(BEATS - 1));

        w_cnt_next  = r_cnt;
        w_word_next = r_word;
        if (i_clear || w_last) begin
            w_cnt_next  = '0;
            w_word_next = '0;
        end else if (i_val) begin
            w_cnt_next  = r_cnt + 1'b1;
            w_word_next = w_word_merged;
        end

        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_val && !w_last && !i_clear) w_state_next = StFill;
            StFill: if (i_clear || w_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_word  <= w_word_next;
        end
    end

    assign o_word = w_word_merged;
    assign o_cnt  = r_cnt;
    assign o_last = w_last;
    assign o_held = (r_state == StFill) || i_val;

endmodule

// File: rtl/deser_param.sv
// Parametrised LANE_W-to-DATA_W deserializer with one-cycle word strobe and bit count.
// Define DESER_FLUSH_EN to let flush_i emit a partially filled word.
module deser_param
    import deser_param_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LANE_W    = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    deser_param_if.slave  bus
);

    localparam int unsigned MOD_W = mod_width(DATA_W);
    localparam int unsigned CNT_W = cnt_width(DATA_W / LANE_W);

    typedef logic [MOD_W-1:0] mod_t;

    `DESER_PARAM_CHECK(DATA_W, LANE_W)

    logic [DATA_W-1:0] w_word;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_last;
    logic              w_held;
    logic              w_flush;
    mod_t              w_mod_part;

    logic [DATA_W-1:0] r_data;
    logic              r_val;
    mod_t              r_mod;

    deser_param_lane_shift #(
        .DATA_W    (DATA_W),
        .LANE_W    (LANE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_lane_shift (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .i_beat   (bus.data_i),
        .i_val    (bus.data_val_i),
        .i_clear  (w_flush),
        .o_word   (w_word),
        .o_cnt    (w_cnt),
        .o_last   (w_last),
        .o_held   (w_held)
    );

`ifdef DESER_FLUSH_EN
    // A completing beat wins over flush so a full word never strobes twice.
    assign w_flush    = bus.flush_i && w_held && !w_last;
    assign w_mod_part = mod_t'((32'(w_cnt) + 32'(bus.data_val_i)) * LANE_W);
`else
    logic w_unused;
    assign w_unused   = ^{bus.flush_i, w_cnt, w_held};
    assign w_flush    = 1'b0;
    assign w_mod_part = mod_t'(DATA_W);
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_data <= '0;
            r_val  <= 1'b0;
            r_mod  <= '0;
        end else begin
            r_val <= w_last || w_flush;
            if (w_last) begin
                r_data <= w_word;
                r_mod  <= mod_t'(DATA_W);
            end else if (w_flush) begin
                r_data <= w_word;
                r_mod  <= w_mod_part;
            end
        end
    end

    assign bus.deser_data_o     = r_data;
    assign bus.deser_data_val_o = r_val;
    assign bus.deser_data_mod_o = r_mod;

endmodule

// File: tb/tb_deser_param.sv
// Bench for deser_param: a 16/1/MSB-first and a 32/4/LSB-first instance against a beat-queue model.
module tb_deser_param;

    localparam int unsigned AW = 16;
    localparam int unsigned AL = 1;
    localparam bit          AM = 1'b1;
    localparam int unsigned BW = 32;
    localparam int unsigned BL = 4;
    localparam bit          BM = 1'b0;
`ifdef DESER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    deser_param_if #(.DATA_W(AW), .LANE_W(AL)) bus_a ();
    deser_param_if #(.DATA_W(BW), .LANE_W(BL)) bus_b ();

    deser_param #(.DATA_W(AW), .LANE_W(AL), .MSB_FIRST(AM)) dut_a (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus_a)
    );

    deser_param #(.DATA_W(BW), .LANE_W(BL), .MSB_FIRST(BM)) dut_b (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Model: beats received so far per instance, plus last emitted word/count.
    int unsigned qa[$];
    int unsigned qb[$];
    logic [63:0] la_data = '0, lb_data = '0;
    int unsigned la_mod = 0, lb_mod = 0;
    bit          ea_val = 1'b0, eb_val = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int unsigned dw, input int unsigned lw,
                                         input bit msb, input int unsigned b[$]);
        logic [63:0] w;
        w = '0;
        for (int unsigned k = 0; k < b.size(); k++) begin
            w = w | (64'(b[k]) << (msb ? (dw - (k + 1) * lw) : (k * lw)));
        end
        return w;
    endfunction

    task automatic model_a(input int unsigned beat, input bit val, input bit flush);
        ea_val = 1'b0;
        if (val) qa.push_back(beat);
        if (qa.size() == AW / AL) begin
            ea_val = 1'b1; la_data = pack(AW, AL, AM, qa); la_mod = AW; qa.delete();
        end else if (FLUSH_EN && flush && qa.size() > 0) begin
            ea_val = 1'b1; la_data = pack(AW, AL, AM, qa); la_mod = qa.size() * AL; qa.delete();
        end
    endtask

    task automatic model_b(input int unsigned beat, input bit val, input bit flush);
        eb_val = 1'b0;
        if (val) qb.push_back(beat);
        if (qb.size() == BW / BL) begin
            eb_val = 1'b1; lb_data = pack(BW, BL, BM, qb); lb_mod = BW; qb.delete();
        end else if (FLUSH_EN && flush && qb.size() > 0) begin
            eb_val = 1'b1; lb_data = pack(BW, BL, BM, qb); lb_mod = qb.size() * BL; qb.delete();
        end
    endtask

    task automatic check_outputs();
        check_eq("a_val", 64'(bus_a.deser_data_val_o), 64'(ea_val));
        check_eq("a_data", 64'(bus_a.deser_data_o), la_data);
        check_eq("a_mod", 64'(bus_a.deser_data_mod_o), 64'(la_mod));
        check_eq("b_val", 64'(bus_b.deser_data_val_o), 64'(eb_val));
        check_eq("b_data", 64'(bus_b.deser_data_o), lb_data);
        check_eq("b_mod", 64'(bus_b.deser_data_mod_o), 64'(lb_mod));
    endtask

    task automatic cycle(input int unsigned ab, input bit av, input bit af,
                         input int unsigned bb, input bit bv, input bit bf);
        @(negedge clk);
        bus_a.data_i = AL'(ab); bus_a.data_val_i = av; bus_a.flush_i = af;
        bus_b.data_i = BL'(bb); bus_b.data_val_i = bv; bus_b.flush_i = bf;
        model_a(ab, av, af);
        model_b(bb, bv, bf);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic cycle_a(input int unsigned ab, input bit av, input bit af);
        cycle(ab, av, af, $urandom_range(0, 15), 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus_a.data_val_i = 1'b0; bus_b.data_val_i = 1'b0;
        bus_a.flush_i = 1'b0; bus_b.flush_i = 1'b0;
        #2 arst_n = 1'b0;
        qa.delete(); qb.delete();
        la_data = '0; lb_data = '0; la_mod = 0; lb_mod = 0; ea_val = 1'b0; eb_val = 1'b0;
        #1 check_outputs();
        @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] pat;
        bus_a.data_i = '0; bus_a.data_val_i = 1'b0; bus_a.flush_i = 1'b0;
        bus_b.data_i = '0; bus_b.data_val_i = 1'b0; bus_b.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        arst_n = 1'b1;

        // All-ones word on A; nibbles 1..8 on B in the first eight cycles.
        for (int unsigned i = 0; i < 16; i++) begin
            cycle(1, 1'b1, 1'b0, i + 1, i < 8, 1'b0);
            if (i == 7) begin
                check_eq("b_nibbles_data", 64'(bus_b.deser_data_o), 64'h8765_4321);
                check_eq("b_nibbles_mod", 64'(bus_b.deser_data_mod_o), 64'd32);
            end
        end
        check_eq("a_ones_data", 64'(bus_a.deser_data_o), 64'hFFFF);
        check_eq("a_ones_mod", 64'(bus_a.deser_data_mod_o), 64'd16);

        // F0F0 then zeros, back-to-back, then again with gaps and toggling data.
        pat = 16'hF0F0;
        for (int unsigned i = 0; i < 16; i++) cycle_a(pat[15-i], 1'b1, 1'b0);
        check_eq("a_f0f0_data", 64'(bus_a.deser_data_o), 64'hF0F0);
        for (int unsigned i = 0; i < 16; i++) cycle_a(0, 1'b1, 1'b0);
        check_eq("a_zero_val", 64'(bus_a.deser_data_val_o), 64'd1);
        for (int unsigned i = 0; i < 32; i++) begin
            repeat ($urandom_range(1, 16)) cycle_a($urandom_range(0, 1), 1'b0, 1'b0);
            cycle_a((i < 16) ? 32'(pat[15-i]) : 0, 1'b1, 1'b0);
            if (i == 15) check_eq("a_gap_f0f0", 64'(bus_a.deser_data_o), 64'hF0F0);
        end

        // Reset discards a partial word.
        for (int unsigned i = 0; i < 7; i++) cycle_a(0, 1'b1, 1'b0);
        pulse_reset();
        for (int unsigned i = 0; i < 16; i++) cycle_a(1, 1'b1, 1'b0);
        check_eq("a_post_reset_data", 64'(bus_a.deser_data_o), 64'hFFFF);

`ifdef DESER_FLUSH_EN
        cycle_a(1, 1'b1, 1'b0); cycle_a(0, 1'b1, 1'b0);
        cycle_a(1, 1'b1, 1'b0); cycle_a(1, 1'b1, 1'b0);
        cycle_a(0, 1'b0, 1'b1);
        check_eq("a_flush_val", 64'(bus_a.deser_data_val_o), 64'd1);
        check_eq("a_flush_data", 64'(bus_a.deser_data_o), 64'hB000);
        check_eq("a_flush_mod", 64'(bus_a.deser_data_mod_o), 64'd4);
        for (int unsigned i = 0; i < 16; i++) cycle_a(1, 1'b1, i == 15);
        check_eq("a_flush_full_mod", 64'(bus_a.deser_data_mod_o), 64'd16);
        cycle_a(0, 1'b0, 1'b1);
        check_eq("a_flush_idle_val", 64'(bus_a.deser_data_val_o), 64'd0);
`endif

        // Random traffic on both instances with sporadic flushes and one reset.
        for (int unsigned i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
